// File: rtl/preg_freelist.sv
// Physical-register free list: circular buffer of unmapped pregs. Allocation is
// taken from head, commit frees are written at tail, and a ROB walk rewinds head.
module preg_freelist #(
  parameter int PREG_SIZE    = 128,
  parameter int ARCH_REGS    = 32,
  parameter int RENAME_WIDTH = 4,
  parameter int COMMIT_WIDTH = 4,
  localparam int FREE_NUM    = PREG_SIZE - ARCH_REGS,
  localparam int PW          = $clog2(PREG_SIZE),
  localparam int IW          = $clog2(FREE_NUM),
  localparam int CW          = $clog2(FREE_NUM + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RENAME_WIDTH-1:0]      alloc_req,
  output logic                         alloc_ready,
  output logic [RENAME_WIDTH*PW-1:0]   alloc_prd,
  input  logic                         redirect,
  input  logic [COMMIT_WIDTH-1:0]      commit_en,
  input  logic [COMMIT_WIDTH-1:0]      commit_we,
  input  logic [COMMIT_WIDTH*PW-1:0]   commit_old_prd,
  input  logic                         walk,
  input  logic [COMMIT_WIDTH-1:0]      walk_en,
  input  logic [COMMIT_WIDTH-1:0]      walk_we,
  output logic [CW-1:0]                free_count,
  output logic                         overflow
);

  localparam logic [IW:0] FN_I = (IW+1)'(FREE_NUM);
  localparam logic [CW:0] FN_C = (CW+1)'(FREE_NUM);

  // FREE_NUM is not a power of two, so wrap with one conditional correction.
  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] base, input logic [IW-1:0] off);
    logic [IW:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= FN_I) s = s - FN_I;
    return s[IW-1:0];
  endfunction

  function automatic logic [IW-1:0] idx_dec(input logic [IW-1:0] base, input logic [IW-1:0] off);
    logic [IW:0] d;
    d = {1'b0, base} - {1'b0, off};
    if (d[IW]) d = d + FN_I;
    return d[IW-1:0];
  endfunction

  logic [PW-1:0] list_q [FREE_NUM];
  logic [PW-1:0] list_d [FREE_NUM];
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          fire;
  logic [IW-1:0] alloc_cnt;
  logic [IW-1:0] free_cnt;
  logic [IW-1:0] walk_cnt;
  logic [CW:0]   cnt_sum;

  always_comb begin
    alloc_ready = (count_q >= CW'(RENAME_WIDTH)) && !redirect && !walk;
    fire        = alloc_ready && (|alloc_req);

    alloc_prd = '0;
    alloc_cnt = '0;
    for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
      if (alloc_req[i]) begin
        alloc_prd[i*PW +: PW] = list_q[idx_inc(head_q, alloc_cnt)];
        alloc_cnt = alloc_cnt + IW'(1);
      end
    end

    list_d   = list_q;
    free_cnt = '0;
    for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
      if (commit_en[j] && commit_we[j]) begin
        list_d[idx_inc(tail_q, free_cnt)] = commit_old_prd[j*PW +: PW];
        free_cnt = free_cnt + IW'(1);
      end
    end

    walk_cnt = '0;
    if (walk) begin
      for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
        if (walk_en[j] && walk_we[j]) walk_cnt = walk_cnt + IW'(1);
      end
    end

    // Allocation and walk never coincide: walk forces alloc_ready low.
    head_d = head_q;
    if (fire)      head_d = idx_inc(head_q, alloc_cnt);
    else if (walk) head_d = idx_dec(head_q, walk_cnt);
    tail_d = idx_inc(tail_q, free_cnt);

    cnt_sum = {1'b0, count_q} - (fire ? (CW+1)'(alloc_cnt) : '0)
            + (CW+1)'(free_cnt) + (CW+1)'(walk_cnt);
    count_d    = cnt_sum[CW-1:0];
    overflow_d = overflow_q;
    if (cnt_sum > FN_C) begin
      count_d    = CW'(FREE_NUM);
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= CW'(FREE_NUM);
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < FREE_NUM; i++) list_q[i] <= PW'(ARCH_REGS + i);
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      list_q     <= list_d;
    end
  end

  assign free_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/preg_freelist.md
# preg_freelist

Physical-register free list for the rename/dispatch stage. Hands out up to RENAME_WIDTH free physical registers per cycle to newly renamed instructions. Reclaims the previous mappings of retiring instructions from commit. On a ROB walk, returns speculatively allocated registers by rolling back its read pointer. It is the allocating counterpart of the busy table: every `alloc_prd` it issues is the destination register the busy table marks not-ready at dispatch.

## Interface
Parameters:
- PREG_SIZE, 128, number of physical registers
- ARCH_REGS, 32, architectural registers; pregs 0..ARCH_REGS-1 are mapped at reset
- RENAME_WIDTH, 4, allocation lanes per cycle
- COMMIT_WIDTH, 4, free/walk lanes per cycle
- Derived: FREE_NUM = PREG_SIZE-ARCH_REGS (96); PW = clog2(PREG_SIZE); IW = clog2(FREE_NUM); CW = clog2(FREE_NUM+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alloc_req  in  RENAME_WIDTH  per-lane request; may be sparse
- alloc_ready  out  1  allocation accepted this cycle when high
- alloc_prd  out  RENAME_WIDTH×PW  register granted to each requesting lane
- redirect  in  1  backend redirect; blocks allocation
- commit_en  in  COMMIT_WIDTH  retiring lane valid
- commit_we  in  COMMIT_WIDTH  lane writes a register
- commit_old_prd  in  COMMIT_WIDTH×PW  previous mapping to free
- walk  in  1  ROB walk in progress
- walk_en  in  COMMIT_WIDTH  walked lane valid
- walk_we  in  COMMIT_WIDTH  walked lane had a destination
- free_count  out  CW  registered number of entries in the list
- overflow  out  1  sticky error flag; set when a free would exceed FREE_NUM

## Operation
- Storage: circular buffer `list[FREE_NUM]` of PW-bit entries. Registers: head (read index), tail (write index), count.
- Reset state: list[i] = ARCH_REGS+i; head = 0; tail = 0; count = FREE_NUM; overflow = 0.
- alloc_ready = (count ≥ RENAME_WIDTH) & ~redirect & ~walk. Depends only on registered count and the two control inputs, not on alloc_req.
- Allocation fire = alloc_ready & |alloc_req. Let k_i = number of set alloc_req bits below lane i.
  - Lane i with a request gets alloc_prd[i] = list[(head+k_i) mod FREE_NUM].
  - Lanes without a request drive don't-care, and the bench ignores them.
  - On fire: head += popcount(alloc_req) mod FREE_NUM.
- Free: lane j frees when commit_en[j] & commit_we[j]. Let m_j = number of freeing lanes below j.
  - list[(tail+m_j) mod FREE_NUM] <= commit_old_prd[j].
  - tail += number of freeing lanes, mod FREE_NUM.
- Walk: when walk is high, w = popcount(walk_en & walk_we), and head -= w mod FREE_NUM.
  - Buffer contents behind head are intact (tail can never reach uncommitted allocations), so the same pregs are reissued later.
- count_next = count − alloc_cnt + free_cnt + w.
  - alloc_cnt and w are mutually exclusive, because allocation is blocked during walk.
- Commit and walk in the same cycle: both apply, on independent pointers.
- overflow: set when count − alloc_cnt + free_cnt + w > FREE_NUM. In that case count saturates at FREE_NUM. overflow clears only on rst.
- Modular arithmetic: index sums are computed at IW+1 bits, with FREE_NUM subtracted once if the result is ≥ FREE_NUM. For decrement, FREE_NUM is added when the result is negative. FREE_NUM is not a power of two, so plain bit-truncation is forbidden.

## Timing
- alloc_prd is combinational from registered head/list and alloc_req; zero-latency grant in the request cycle.
- head, tail, count, list and free_count update at the clk edge after fire/free/walk.
- A register freed in cycle t can first be allocated in cycle t+1, and only after all older list entries.
- Freed registers do not contribute to alloc_ready in the same cycle.
- redirect or walk high forces alloc_ready = 0 in the same cycle; head does not advance for allocation.
- rst asserted mid-operation: all state returns asynchronously to the reset values, including any in-flight walk. free_count = FREE_NUM and alloc_ready = 1 (if redirect and walk are low) in the first cycle after rst deasserts.

## Test plan
- Reset, then alloc_req=1111 → alloc_prd = 32,33,34,35; next cycle free_count = 92.
- Sparse alloc_req=1010 after the above → lane1 = 36, lane3 = 37; free_count = 90.
- Allocate until free_count = 3 → alloc_ready = 0 and head unchanged. Then commit frees pregs 5 and 9 → free_count = 5, alloc_ready = 1, and the grants after the remaining older entries are 5 then 9.
- Allocate 4 (40..43), then walk with walk_en=1100, walk_we=1100 → free_count += 2; next alloc_req=0011 yields 42,43.
- Run more than 96 alloc/free pairs → head and tail wrap 95→0 correctly; freed values are reissued in FIFO order; overflow stays 0.
- Free at full (count=96) with one commit_we lane → overflow = 1 and free_count stays 96; redirect=1 with alloc_req=1111 → alloc_ready = 0 and no pointer change.
